// File: rtl/l2_cache_assoc_if.sv
// l2_cache_assoc_if: bus bundle for the shared L2 cache.
//   Carries the dcache request port, the icache request port, the shared
//   response (cache_data, cache_err) and the 32-bit word-serial memory port.
//   modport slave  : the cache side (takes requests, drives the memory port)
//   modport master : the environment side (clients plus backing memory)
// Parameter LINE_WORDS must match the cache instance it is connected to.
interface l2_cache_assoc_if #(
  parameter int LINE_WORDS = 4
);
  localparam int LW = 32 * LINE_WORDS;

  logic          dcache_r;
  logic          dcache_w;
  logic [31:0]   dcache_addr;
  logic [LW-1:0] dcache_data_in;
  logic          cache_ready_d;
  logic          icache_r;
  logic [31:0]   icache_addr;
  logic          cache_ready_i;
  logic [LW-1:0] cache_data;
  logic          cache_err;
  logic          mem_ready;
  logic [31:0]   mem_data;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_data_out;
  logic          mem_r;
  logic          mem_w;

  modport slave (
    input  dcache_r, dcache_w, dcache_addr, dcache_data_in,
    input  icache_r, icache_addr,
    input  mem_ready, mem_data,
    output cache_ready_d, cache_ready_i, cache_data, cache_err,
    output mem_addr, mem_data_out, mem_r, mem_w
  );

  modport master (
    output dcache_r, dcache_w, dcache_addr, dcache_data_in,
    output icache_r, icache_addr,
    output mem_ready, mem_data,
    input  cache_ready_d, cache_ready_i, cache_data, cache_err,
    input  mem_addr, mem_data_out, mem_r, mem_w
  );
endinterface

// File: rtl/l2_cache_assoc.sv
// l2_cache_assoc: 2-way set-associative, write-back, write-allocate unified L2.
//   Serves icache line reads and dcache line reads / whole-line writes; the
//   dcache wins arbitration. Misses go to a 32-bit word-serial memory port.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (aborts any transaction)
//   bus      l2_cache_assoc_if.slave: request ports, response, memory port
//   hit_cnt  / miss_cnt  [31:0] lookup counters, present only when the
//            macro L2_PERF_CNT_EN is defined
// Parameters: INDEX_BITS (sets = 2**INDEX_BITS), LINE_WORDS (words per line).
// All outputs are registered.
module l2_cache_assoc #(
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4
) (
  input  logic            clk,
  input  logic            rst,
  l2_cache_assoc_if.slave bus
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0]     hit_cnt,
  output logic [31:0]     miss_cnt
`endif
);
  localparam int LW   = 32 * LINE_WORDS;
  localparam int OFF  = $clog2(4 * LINE_WORDS);
  localparam int CW   = $clog2(LINE_WORDS);
  localparam int BW   = 32 - OFF;          // block address = tag + index
  localparam int TW   = BW - INDEX_BITS;
  localparam int SETS = 2 ** INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WB     = 3'd2,
    FILL   = 3'd3,
    RESP   = 3'd4
  } state_t;

  function automatic logic [31:0] word_of(input logic [LW-1:0] line, input logic [CW-1:0] i);
    return line[{i, 5'd0} +: 32];
  endfunction

  function automatic logic [LW-1:0] set_word(input logic [LW-1:0] line, input logic [CW-1:0] i,
                                             input logic [31:0] w);
    logic [LW-1:0] l;
    l = line;
    l[{i, 5'd0} +: 32] = w;
    return l;
  endfunction

  state_t          state_r, state_s;
  logic [TW-1:0]   tag_arr_r  [2][SETS];
  logic [LW-1:0]   data_arr_r [2][SETS];
  logic [1:0]      valid_r    [SETS];
  logic [1:0]      dirty_r    [SETS];
  logic [SETS-1:0] lru_r;                  // way to evict next

  logic            req_d_r, req_w_r;
  logic [BW-1:0]   blk_r;
  logic [LW-1:0]   wdata_r, line_r, line_s;
  logic            way_r, way_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [LW-1:0]   cache_data_r, cache_data_s;
  logic            rdy_d_r, rdy_d_s, rdy_i_r, rdy_i_s, err_r, err_s;
  logic            mem_r_r, mem_r_s, mem_w_r, mem_w_s;
  logic [31:0]     mem_addr_r, mem_addr_s, mem_dout_r, mem_dout_s;

  logic            acc_d_s, acc_i_s, finish_s;
  logic            arr_we_s, arr_way_s, arr_dirty_s, data_we_s;
  logic [LW-1:0]   data_line_s;
  logic            hit_s, miss_s;

  logic [INDEX_BITS-1:0] idx_s;
  logic [TW-1:0]   req_tag_s;
  logic            hit0_s, hit1_s, vict_s, last_s;

  assign idx_s     = blk_r[INDEX_BITS-1:0];
  assign req_tag_s = blk_r[BW-1:INDEX_BITS];
  assign hit0_s    = valid_r[idx_s][0] && (tag_arr_r[0][idx_s] == req_tag_s);
  assign hit1_s    = valid_r[idx_s][1] && (tag_arr_r[1][idx_s] == req_tag_s);
  // Invalid ways are filled first (way0 before way1); otherwise evict LRU.
  assign vict_s    = !valid_r[idx_s][0] ? 1'b0 : (!valid_r[idx_s][1] ? 1'b1 : lru_r[idx_s]);
  assign last_s    = &cnt_r;

  // Next-state, array-update and next-output computation
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    way_s        = way_r;
    line_s       = line_r;
    cache_data_s = cache_data_r;
    rdy_d_s      = 1'b0;
    rdy_i_s      = 1'b0;
    err_s        = 1'b0;
    mem_r_s      = 1'b0;
    mem_w_s      = 1'b0;
    mem_addr_s   = 32'd0;
    mem_dout_s   = 32'd0;
    acc_d_s      = 1'b0;
    acc_i_s      = 1'b0;
    finish_s     = 1'b0;
    arr_we_s     = 1'b0;
    arr_way_s    = way_r;
    arr_dirty_s  = 1'b0;
    data_we_s    = 1'b0;
    data_line_s  = wdata_r;
    hit_s        = 1'b0;
    miss_s       = 1'b0;

    case (state_r)
      IDLE: begin
        if (bus.dcache_r || bus.dcache_w) begin
          acc_d_s = 1'b1;
          if (bus.dcache_r && bus.dcache_w) begin
            // Malformed request: answer with an error, touch nothing.
            state_s = RESP;
            rdy_d_s = 1'b1;
            err_s   = 1'b1;
          end else begin
            state_s = LOOKUP;
          end
        end else if (bus.icache_r) begin
          acc_i_s = 1'b1;
          state_s = LOOKUP;
        end else begin
          state_s = IDLE;
        end
      end
      LOOKUP: begin
        if (hit0_s || hit1_s) begin
          hit_s     = 1'b1;
          way_s     = hit1_s;
          arr_we_s  = 1'b1;
          arr_way_s = hit1_s;
          if (req_w_r) begin
            arr_dirty_s = 1'b1;
            data_we_s   = 1'b1;
          end else begin
            arr_dirty_s  = dirty_r[idx_s][hit1_s];
            cache_data_s = data_arr_r[hit1_s][idx_s];
          end
          state_s  = RESP;
          finish_s = 1'b1;
        end else begin
          miss_s = 1'b1;
          way_s  = vict_s;
          cnt_s  = {CW{1'b0}};
          if (valid_r[idx_s][vict_s] && dirty_r[idx_s][vict_s]) begin
            state_s = WB;
          end else if (req_w_r) begin
            arr_we_s    = 1'b1;
            arr_way_s   = vict_s;
            arr_dirty_s = 1'b1;
            data_we_s   = 1'b1;
            state_s     = RESP;
            finish_s    = 1'b1;
          end else begin
            state_s = FILL;
          end
        end
      end
      WB: begin
        if (bus.mem_ready) begin
          if (last_s) begin
            cnt_s = {CW{1'b0}};
            if (req_w_r) begin
              arr_we_s    = 1'b1;
              arr_dirty_s = 1'b1;
              data_we_s   = 1'b1;
              state_s     = RESP;
              finish_s    = 1'b1;
            end else begin
              state_s = FILL;
            end
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end else begin
          state_s = WB;
        end
      end
      FILL: begin
        if (bus.mem_ready) begin
          line_s = set_word(line_r, cnt_r, bus.mem_data);
          if (last_s) begin
            cnt_s        = {CW{1'b0}};
            arr_we_s     = 1'b1;
            arr_dirty_s  = 1'b0;
            data_we_s    = 1'b1;
            data_line_s  = line_s;
            cache_data_s = line_s;
            state_s      = RESP;
            finish_s     = 1'b1;
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end else begin
          state_s = FILL;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase

    // Ready is registered on entry to RESP so the pulse lines up with RESP.
    rdy_d_s = rdy_d_s | (finish_s & req_d_r);
    rdy_i_s = rdy_i_s | (finish_s & ~req_d_r);

    // Memory strobes/address are registered from the next state and counter.
    case (state_s)
      WB: begin
        mem_w_s    = 1'b1;
        mem_addr_s = {tag_arr_r[way_s][idx_s], idx_s, cnt_s, 2'b00};
        mem_dout_s = word_of(data_arr_r[way_s][idx_s], cnt_s);
      end
      FILL: begin
        mem_r_s    = 1'b1;
        mem_addr_s = {blk_r, cnt_s, 2'b00};
      end
      default: mem_addr_s = 32'd0;
    endcase
  end

  // FSM state, request latch and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      way_r        <= 1'b0;
      req_d_r      <= 1'b0;
      req_w_r      <= 1'b0;
      blk_r        <= {BW{1'b0}};
      wdata_r      <= {LW{1'b0}};
      line_r       <= {LW{1'b0}};
      cache_data_r <= {LW{1'b0}};
      rdy_d_r      <= 1'b0;
      rdy_i_r      <= 1'b0;
      err_r        <= 1'b0;
      mem_r_r      <= 1'b0;
      mem_w_r      <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_dout_r   <= 32'd0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      way_r        <= way_s;
      line_r       <= line_s;
      cache_data_r <= cache_data_s;
      rdy_d_r      <= rdy_d_s;
      rdy_i_r      <= rdy_i_s;
      err_r        <= err_s;
      mem_r_r      <= mem_r_s;
      mem_w_r      <= mem_w_s;
      mem_addr_r   <= mem_addr_s;
      mem_dout_r   <= mem_dout_s;
      if (acc_d_s) begin
        req_d_r <= 1'b1;
        req_w_r <= bus.dcache_w;
        blk_r   <= bus.dcache_addr[31:OFF];
        wdata_r <= bus.dcache_data_in;
      end else if (acc_i_s) begin
        req_d_r <= 1'b0;
        req_w_r <= 1'b0;
        blk_r   <= bus.icache_addr[31:OFF];
      end
    end
  end

  // Valid/dirty/LRU metadata, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= 2'b00;
        dirty_r[s] <= 2'b00;
      end
      lru_r <= {SETS{1'b0}};
    end else if (arr_we_s) begin
      valid_r[idx_s][arr_way_s] <= 1'b1;
      dirty_r[idx_s][arr_way_s] <= arr_dirty_s;
      lru_r[idx_s]              <= ~arr_way_s;
    end
  end

  // Tag and data storage, intentionally left unreset
  always_ff @(posedge clk) begin
    if (arr_we_s && !rst) begin
      tag_arr_r[arr_way_s][idx_s] <= req_tag_s;
    end
    if (data_we_s && !rst) begin
      data_arr_r[arr_way_s][idx_s] <= data_line_s;
    end
  end

  assign bus.cache_ready_d = rdy_d_r;
  assign bus.cache_ready_i = rdy_i_r;
  assign bus.cache_err     = err_r;
  assign bus.cache_data    = cache_data_r;
  assign bus.mem_r         = mem_r_r;
  assign bus.mem_w         = mem_w_r;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.mem_data_out  = mem_dout_r;

`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_cnt_r, miss_cnt_r;

  // Lookup hit/miss counters; wrap naturally at 2**32
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else begin
      hit_cnt_r  <= hit_cnt_r + {31'd0, hit_s};
      miss_cnt_r <= miss_cnt_r + {31'd0, miss_s};
    end
  end

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;
`endif
endmodule

// File: doc/l2_cache_assoc.md
Name: l2_cache_assoc

Overview:
- Parametrised successor of the L2 cache: 2-way set-associative, write-back, write-allocate unified L2.
- Shared by the icache (line reads only) and the dcache (line reads and whole-line writebacks).
- Backed by a 32-bit word-serial memory port. Line width, set count and line length are parameters. Includes LRU replacement, dirty eviction and fixed dcache-over-icache arbitration.

Parameters:
INDEX_BITS, 6, set index width; sets = 2**INDEX_BITS
LINE_WORDS, 4, 32-bit words per line, power of two >= 2; line width LW = 32*LINE_WORDS

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
dcache_r  in  1  dcache line read request, held until cache_ready_d
dcache_w  in  1  dcache line write request, held until cache_ready_d
dcache_addr  in  32  dcache byte address; offset bits ignored
dcache_data_in  in  LW  full line to write
cache_ready_d  out  1  one-cycle done pulse for the dcache request
icache_r  in  1  icache line read request, held until cache_ready_i
icache_addr  in  32  icache byte address
cache_ready_i  out  1  one-cycle done pulse for the icache request
cache_data  out  LW  read line; valid with the ready pulse and held until the next read completes
cache_err  out  1  one-cycle error pulse, coincident with cache_ready_d
mem_ready  in  1  one-cycle pulse: current memory word done
mem_data  in  32  memory read word
mem_addr  out  32  memory word address
mem_data_out  out  32  memory write word
mem_r  out  1  memory read strobe, held until mem_ready
mem_w  out  1  memory write strobe, held until mem_ready

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Address split:
  - OFF = log2(4*LINE_WORDS) low bits are the offset.
  - Next INDEX_BITS bits are the set index.
  - Remaining bits are the tag.
- Per-set state: valid[2], dirty[2], tag[2], lru (lru names the way to evict next).
  - Valid, dirty and lru are cleared by rst.
  - Tag and data arrays are not reset.
- Output reset values: all outputs are 0. FSM goes to IDLE.
- FSM states: IDLE, LOOKUP, WB, FILL, RESP.
  - IDLE:
    - Arbitration: (dcache_r|dcache_w) wins over icache_r.
    - On acceptance, latch requester, address, kind and write data, then go to LOOKUP.
    - If dcache_r&dcache_w: go to RESP with the err flag set. No array or memory access occurs.
  - LOOKUP: compare the tag against both valid ways.
    - Read hit: load cache_data from the hit way. Set lru = other way. Go to RESP.
    - Write hit: replace the line. Set dirty = 1 and lru = other way. Go to RESP.
    - Miss, victim selection: an invalid way is chosen first (way0 before way1); otherwise way lru.
    - Miss with a valid, dirty victim: go to WB.
    - Miss otherwise: a read goes to FILL; a write installs the line (valid = 1, dirty = 1, new tag, lru = other way) and goes to RESP.
  - WB:
    - Word counter i runs 0..LINE_WORDS-1.
    - mem_w = 1, mem_addr = {victim tag, index, i, 2'b00}, mem_data_out = victim word i.
    - Advance on mem_ready.
    - After the last word: a read goes to FILL; a write installs the line as in LOOKUP and goes to RESP.
  - FILL:
    - mem_r = 1, mem_addr = {req tag, index, i, 2'b00}.
    - On mem_ready, capture mem_data into word i of the victim.
    - After the last word: valid = 1, dirty = 0, tag written, lru = other way, cache_data = filled line. Go to RESP.
  - RESP:
    - Pulse the requester's ready for exactly one cycle (cache_err with it if flagged). Return to IDLE.
    - The requester drops its request in the cycle ready is seen, so IDLE never re-accepts it.
- Memory strobes:
  - mem_r/mem_w are deasserted in the cycle after the final mem_ready.
  - Never both high.
  - mem_addr is stable while a strobe is high.
- Latency:
  - Hit: ready in the 3rd cycle after the request is first sampled in IDLE.
  - Miss: add one cycle per word of WB/FILL beyond memory wait.
- A request arriving during a busy period waits. A losing icache request is served after the dcache transaction.
- Reset mid-transaction: abort and return to IDLE. Strobes and ready drop at that edge. Dirty data is discarded.

Optional Feature:
- Macro: L2_PERF_CNT_EN.
- When defined, adds output ports hit_cnt [31:0] and miss_cnt [31:0].
  - The counters increment once per LOOKUP hit and once per LOOKUP miss.
  - They wrap at 2**32 and are cleared by rst. Error transactions count neither.
- When undefined, the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Cold icache_r at 0x00000040; memory returns 0xA0, 0xA1, 0xA2, 0xA3 -> four mem_r beats at 0x40/0x44/0x48/0x4C; cache_ready_i pulse; cache_data = {A3,A2,A1,A0}; no mem_w.
- Repeat the same read -> hit; ready in the 3rd cycle; no memory traffic; hit_cnt = 1 if enabled.
- dcache_w to 0x1000, 0x2000, 0x3000 (same set 0, INDEX_BITS = 6), then dcache_r 0x1000 -> third write evicts the 0x1000 line (LRU) with 4 mem_w beats at 0x1000..0x100C carrying the written data; the final read refills from 0x1000.
- dcache_r and icache_r raised in the same cycle -> cache_ready_d completes first; icache served next; ready pulses never overlap.
- dcache_r & dcache_w both high -> cache_ready_d and cache_err pulse together; no mem strobes; tag state unchanged.
- rst asserted during the 2nd FILL beat -> mem_r low at the next edge; all outputs 0; a following read of the same address misses.
